feather_pe_out_collector: RTL and testbench

//  Downstream drain for one column of feather PEs: captures each PE's o_out_data/o_out_data_valid pulse.

---
 rtl/feather_pkg.sv | 11 +
 rtl/feather_lane_fifo.sv | 44 ++++
 rtl/feather_pe_out_collector.sv | 81 ++++++++
 tb/tb_feather_pe_out_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/feather_pkg.sv
// feather_pkg: shared defaults, a clog2 helper and the flat-bus lane-slice macro for the feather PE output path
`define FEATHER_LANE(bus, k, w) bus[(k)*(w) +: (w)]
package feather_pkg;
  localparam int DEFAULT_PE_OUTPUT_WIDTH = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/feather_lane_fifo.sv
// feather_lane_fifo: small circular FIFO for one PE lane; a push into a full lane lands only if the head leaves the same cycle
module feather_lane_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOG2_DEPTH:0] cnt_q, cnt_d;
  logic wr_en;
  always_comb begin
    wr_en = push & (!full | pop) & !flush;
    wr_d = flush ? '0 : wr_q + LOG2_DEPTH'(wr_en);
    rd_d = flush ? '0 : rd_q + LOG2_DEPTH'(pop);
    cnt_d = flush ? '0 : cnt_q + (LOG2_DEPTH+1)'(wr_en) - (LOG2_DEPTH+1)'(pop);
  end
  assign empty = cnt_q == '0;
  assign full = cnt_q == (LOG2_DEPTH+1)'(DEPTH);
  assign head_data = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/feather_pe_out_collector.sv
// feather_pe_out_collector: buffers per-PE result pulses and merges them round-robin into one tagged valid/ready stream
module feather_pe_out_collector
  import feather_pkg::*;
#(
  parameter int NUM_PES = 4,
  parameter int PE_OUTPUT_WIDTH = DEFAULT_PE_OUTPUT_WIDTH,
  parameter int PE_ID_WIDTH = clog2(NUM_PES),
  parameter int LANE_FIFO_DEPTH = 4,
  parameter int LOG2_LANE_FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PES*PE_OUTPUT_WIDTH-1:0] i_pe_out_data,
  input  logic [NUM_PES-1:0]                 i_pe_out_valid,
  input  logic                               i_flush,
  output logic [PE_OUTPUT_WIDTH-1:0]         o_data,
  output logic [PE_ID_WIDTH-1:0]             o_pe_id,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [NUM_PES-1:0]                 o_overflow,
  output logic                               o_idle
);
  logic [NUM_PES-1:0] req, masked, pop, full, empty, ovf_q, ovf_d;
  logic [PE_OUTPUT_WIDTH-1:0] head [NUM_PES];
  logic [PE_OUTPUT_WIDTH-1:0] data_q, data_d;
  logic [PE_ID_WIDTH-1:0] grant, rr_q, rr_d, pe_id_q, pe_id_d;
  logic valid_q, valid_d, load, take;
  for (genvar k = 0; k < NUM_PES; k++) begin : g_lane
    feather_lane_fifo #(
      .W(PE_OUTPUT_WIDTH),
      .DEPTH(LANE_FIFO_DEPTH),
      .LOG2_DEPTH(LOG2_LANE_FIFO_DEPTH)
    ) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(i_flush),
      .push(i_pe_out_valid[k]),
      .push_data(`FEATHER_LANE(i_pe_out_data, k, PE_OUTPUT_WIDTH)),
      .pop(pop[k]),
      .head_data(head[k]),
      .empty(empty[k]),
      .full(full[k])
    );
  end
  // masked priority encoder: lanes at or above rr_q win first, otherwise wrap to the lowest requester
  always_comb begin
    req = ~empty;
    for (int i = 0; i < NUM_PES; i++) masked[i] = req[i] & (PE_ID_WIDTH'(i) >= rr_q);
    grant = '0;
    for (int i = NUM_PES - 1; i >= 0; i--) if (req[i]) grant = PE_ID_WIDTH'(i);
    for (int i = NUM_PES - 1; i >= 0; i--) if (masked[i]) grant = PE_ID_WIDTH'(i);
    load = !valid_q | i_ready;
    take = load & (|req) & !i_flush;
    pop = take ? NUM_PES'(1) << grant : '0;
    valid_d = i_flush ? 1'b0 : load ? |req : valid_q;
    data_d = take ? head[grant] : data_q;
    pe_id_d = take ? grant : pe_id_q;
    rr_d = i_flush ? '0 : take ? ((grant == PE_ID_WIDTH'(NUM_PES - 1)) ? '0 : grant + 1'b1) : rr_q;
    ovf_d = i_flush ? '0 : ovf_q | (i_pe_out_valid & full & ~pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      pe_id_q <= '0;
      rr_q <= '0;
      ovf_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      pe_id_q <= pe_id_d;
      rr_q <= rr_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_valid = valid_q;
  assign o_data = data_q;
  assign o_pe_id = pe_id_q;
  assign o_overflow = ovf_q;
  assign o_idle = !valid_q & ~|req;
endmodule

// File: tb/tb_feather_pe_out_collector.sv
// tb_feather_pe_out_collector: table-driven bursts plus hand-written stall, flush, alternation and reset sequences
module tb_feather_pe_out_collector;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*W-1:0] i_pe_out_data = '0;
  logic [N-1:0] i_pe_out_valid = '0;
  logic i_flush = 1'b0;
  logic i_ready = 1'b0;
  logic [W-1:0] o_data;
  logic [IW-1:0] o_pe_id;
  logic o_valid;
  logic [N-1:0] o_overflow;
  logic o_idle;
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic [IW-1:0] id; logic [W-1:0] data;} beat_t;
  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0][W-1:0] d;
    int n;
    logic [N-1:0][IW-1:0] ids;
  } vec_t;
  beat_t exp_q[$];
  beat_t mon_e;
  vec_t vecs[5];

  feather_pe_out_collector #(
    .NUM_PES(N),
    .PE_OUTPUT_WIDTH(W),
    .PE_ID_WIDTH(IW),
    .LANE_FIFO_DEPTH(4),
    .LOG2_LANE_FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_pe_out_data(i_pe_out_data),
    .i_pe_out_valid(i_pe_out_valid),
    .i_flush(i_flush),
    .o_data(o_data),
    .o_pe_id(o_pe_id),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_overflow(o_overflow),
    .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (!(o_idle && exp_q.size() == 0) && k < 50) begin
      step();
      k++;
    end
    chk(nm, 64'(o_idle && exp_q.size() == 0), 64'd1);
  endtask

  // scoreboard: every accepted beat must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 64'(o_pe_id), 64'hFFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("beat_id", 64'(o_pe_id), 64'(mon_e.id));
        chk("beat_data", 64'(o_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b1111, {32'd40, 32'd30, 32'd20, 32'd10}, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{4'b0100, {32'h0, 32'hAB, 32'h0, 32'h0}, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[2] = '{4'b1010, {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0}, 2, {2'd0, 2'd0, 2'd1, 2'd3}};
    vecs[3] = '{4'b0111, {32'h0, 32'hFFFF_FFA2, 32'h8000_00A1, 32'h0000_00A0}, 3, {2'd0, 2'd1, 2'd0, 2'd2}};
    vecs[4] = '{4'b1001, {32'h0123_4567, 32'h0, 32'h0, 32'hDEAD_BEEF}, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_id", 64'(o_pe_id), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_idle", 64'(o_idle), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    i_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++) exp_q.push_back({vecs[v].ids[j], vecs[v].d[vecs[v].ids[j]]});
      i_pe_out_valid = vecs[v].mask;
      i_pe_out_data = vecs[v].d;
      step();
      i_pe_out_valid = '0;
      chk("lat_edge_t", 64'(o_valid), 64'd0);
      step();
      chk("lat_edge_t1_valid", 64'(o_valid), 64'd1);
      chk("lat_edge_t1_id", 64'(o_pe_id), 64'(vecs[v].ids[0]));
      wait_drain("drain_vec");
    end
    // stall: six pulses on lane 0, five fit (output register + four entries)
    i_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p < 5) exp_q.push_back({2'd0, 32'hC000_0000 + 32'(p)});
      i_pe_out_valid = 4'b0001;
      i_pe_out_data = {96'b0, 32'hC000_0000 + 32'(p)};
      step();
    end
    i_pe_out_valid = '0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_data", 64'(o_data), 64'hC000_0000);
      chk("stall_valid", 64'(o_valid), 64'd1);
      step();
    end
    chk("stall_ovf", 64'(o_overflow), 64'b0001);
    i_ready = 1'b1;
    wait_drain("drain_stall");
    // flush with concurrent pushes
    i_ready = 1'b0;
    i_pe_out_valid = 4'b0110;
    i_pe_out_data = {32'h0, 32'h22, 32'h11, 32'h0};
    step();
    step();
    i_pe_out_valid = '0;
    chk("preflush_valid", 64'(o_valid), 64'd1);
    chk("preflush_ovf", 64'(o_overflow), 64'b0001);
    i_flush = 1'b1;
    i_pe_out_valid = 4'b1111;
    step();
    i_flush = 1'b0;
    i_pe_out_valid = '0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ovf", 64'(o_overflow), 64'd0);
    chk("flush_idle", 64'(o_idle), 64'd1);
    i_ready = 1'b1;
    repeat (4) step();
    chk("flush_stay_idle", 64'(o_idle), 64'd1);
    // lanes 0 and 3 continuously valid: strict alternation from rr_ptr 0
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back({2'd0, 32'h5000_0000 + 32'(c)});
      exp_q.push_back({2'd3, 32'h5300_0000 + 32'(c)});
    end
    for (int c = 0; c < 6; c++) begin
      i_pe_out_valid = 4'b1001;
      i_pe_out_data = {32'h5300_0000 + 32'(c), 64'b0, 32'h5000_0000 + 32'(c)};
      step();
    end
    i_pe_out_valid = '0;
    wait_drain("drain_alt");
    chk("alt_ovf", 64'(o_overflow), 64'd0);
    // fill lane 1, then push into the full lane on the cycle its head pops
    i_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      exp_q.push_back({2'd1, 32'h4100_0000 + 32'(p)});
      if (p == 5) i_ready = 1'b1;
      i_pe_out_valid = 4'b0010;
      i_pe_out_data = {64'b0, 32'h4100_0000 + 32'(p), 32'b0};
      step();
    end
    i_pe_out_valid = '0;
    wait_drain("drain_full_pop");
    chk("full_pop_ovf", 64'(o_overflow), 64'd0);
    // asynchronous reset in the middle of a burst
    i_pe_out_valid = 4'b1111;
    i_pe_out_data = {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000};
    step();
    i_pe_out_valid = '0;
    step();
    chk("mid_valid", 64'(o_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_id", 64'(o_pe_id), 64'd0);
    chk("arst_ovf", 64'(o_overflow), 64'd0);
    chk("arst_idle", 64'(o_idle), 64'd1);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_idle", 64'(o_idle), 64'd1);
    chk("post_rst_valid", 64'(o_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
